// File: rtl/sisc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : sisc_fetch_unit_if
// Description : Instruction-memory read handshake between the SISC fetch
//               stage (master) and instruction memory (slave).
//               imem_req   - read request, held until ack or abort
//               imem_addr  - word address, stable while imem_req is high
//               imem_ack   - imem_rdata is valid this cycle
//               imem_rdata - instruction word
// Revision    : 1.0 - initial release
// ============================================================================
interface sisc_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sisc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : sisc_fetch_unit
// Description : SISC instruction-fetch stage. Owns the PC and the instruction
//               register, runs the instruction-memory handshake with a wait
//               timeout, and applies the control FSM's PC sequencing/branch
//               controls.
// Ports       : clk, rst_f            - clock, async active-low reset
//               ir_load               - start a fetch at the current PC
//               pc_write/pc_sel/br_sel- PC update controls
//               imem (master modport) - instruction-memory handshake
//               instr/opcode/mm/imm   - IR contents and its fields
//               pc_out                - current PC
//               fetch_busy            - a fetch is outstanding
//               fetch_err             - sticky fetch-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module sisc_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  wire logic              clk,
  input  wire logic              rst_f,
  input  wire logic              ir_load,
  input  wire logic              pc_write,
  input  wire logic              pc_sel,
  input  wire logic              br_sel,
  sisc_fetch_unit_if.master      imem,
  output logic [DATA_W-1:0]      instr,
  output logic [3:0]             opcode,
  output logic [3:0]             mm,
  output logic [15:0]            imm,
  output logic [ADDR_W-1:0]      pc_out,
  output logic                   fetch_busy,
  output logic                   fetch_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Counter value on the last permitted wait cycle; a missing ack on that
  // cycle aborts the fetch.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] imm_sext;
  logic [DATA_W-1:0] ir;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              err;

  // Branch immediates always come from the current IR.
  assign imm      = ir[15:0];
  assign opcode   = ir[31:28];
  assign mm       = ir[27:24];
  assign instr    = ir;
  assign pc_out   = pc;
  assign imm_sext = ADDR_W'($signed(imm));

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (pc_sel) begin
      if (br_sel) pc_next = ADDR_W'(imm);
      else        pc_next = pc + imm_sext;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pc       <= '0;
      ir       <= '0;
      req      <= 1'b0;
      addr     <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // PC update is independent of fetch state; a same-cycle fetch latches
      // the pre-update PC because both use the old register value.
      if (pc_write) pc <= pc_next;

      case (state)
        IDLE: begin
          if (ir_load) begin
            addr     <= pc;
            req      <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          // Ack has priority over the timeout on the final wait cycle.
          if (imem.imem_ack) begin
            ir    <= imem.imem_rdata;
            req   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            ir       <= '0;
            err      <= 1'b1;
            req      <= 1'b0;
            busy     <= 1'b0;
            wait_cnt <= wait_cnt + 8'd1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign fetch_busy     = busy;
  assign fetch_err      = err;

endmodule
`default_nettype wire

// File: tb/tb_sisc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sisc_fetch_unit
// Description : Directed self-checking bench for sisc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        fetch_busy;
  logic        fetch_err;

  int vec;
  int errs;

  sisc_fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) imem_if ();

  sisc_fetch_unit #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .imem       (imem_if),
    .instr      (instr),
    .opcode     (opcode),
    .mm         (mm),
    .imm        (imm),
    .pc_out     (pc_out),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch of one word at the current PC.
  task automatic do_fetch(input logic [31:0] data);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = data;
    step();
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = '0;
  endtask

  task automatic pc_op(input logic sel, input logic bsel);
    pc_write = 1'b1;
    pc_sel   = sel;
    br_sel   = bsel;
    step();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = '0;
    step(); step();
    vec++; if (pc_out !== 16'h0) begin errs++; $display("FAIL reset_pc: got %h expected 0000", pc_out); end
    vec++; if (instr !== 32'h0) begin errs++; $display("FAIL reset_ir: got %h expected 00000000", instr); end
    vec++; if (imem_if.imem_req !== 1'b0 || imem_if.imem_addr !== 16'h0) begin errs++;
      $display("FAIL reset_req_addr: got %b/%h expected 0/0000", imem_if.imem_req, imem_if.imem_addr); end
    vec++; if (fetch_busy !== 1'b0 || fetch_err !== 1'b0) begin errs++;
      $display("FAIL reset_flags: got busy=%b err=%b expected 0/0", fetch_busy, fetch_err); end
    rst_f = 1'b1;
    step();
  endtask

  task automatic test_basic_fetch();
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    vec++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 16'h0 || fetch_busy !== 1'b1) begin errs++;
      $display("FAIL basic_req: got req=%b addr=%h busy=%b expected 1/0000/1", imem_if.imem_req, imem_if.imem_addr, fetch_busy); end
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h81230005;
    step();
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = '0;
    vec++; if (instr !== 32'h81230005) begin errs++; $display("FAIL basic_ir: got %h expected 81230005", instr); end
    vec++; if (opcode !== 4'h8 || mm !== 4'h1 || imm !== 16'h0005) begin errs++;
      $display("FAIL basic_fields: got %h/%h/%h expected 8/1/0005", opcode, mm, imm); end
    vec++; if (fetch_busy !== 1'b0 || imem_if.imem_req !== 1'b0) begin errs++;
      $display("FAIL basic_done: got busy=%b req=%b expected 0/0", fetch_busy, imem_if.imem_req); end
  endtask

  task automatic test_fetch_with_pc_write();
    do_fetch(32'h00000010);
    pc_op(1'b1, 1'b1);
    vec++; if (pc_out !== 16'h0010) begin errs++; $display("FAIL setup_pc: got %h expected 0010", pc_out); end
    ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    step();
    ir_load = 1'b0; pc_write = 1'b0;
    vec++; if (imem_if.imem_addr !== 16'h0010) begin errs++; $display("FAIL same_cycle_addr: got %h expected 0010", imem_if.imem_addr); end
    vec++; if (pc_out !== 16'h0011) begin errs++; $display("FAIL same_cycle_pc: got %h expected 0011", pc_out); end
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h00000040;
    step();
    imem_if.imem_ack = 1'b0;
  endtask

  task automatic test_branch();
    pc_op(1'b1, 1'b1);
    vec++; if (pc_out !== 16'h0040) begin errs++; $display("FAIL br_abs: got %h expected 0040", pc_out); end
    pc_op(1'b0, 1'b0);
    vec++; if (pc_out !== 16'h0041) begin errs++; $display("FAIL pc_inc: got %h expected 0041", pc_out); end
    do_fetch(32'h1000FFFE);
    pc_op(1'b1, 1'b0);
    vec++; if (pc_out !== 16'h003F) begin errs++; $display("FAIL br_rel_neg: got %h expected 003F", pc_out); end
    do_fetch(32'h0000FFFF);
    pc_op(1'b1, 1'b1);
    vec++; if (pc_out !== 16'hFFFF) begin errs++; $display("FAIL br_abs_max: got %h expected FFFF", pc_out); end
    pc_op(1'b0, 1'b0);
    vec++; if (pc_out !== 16'h0000) begin errs++; $display("FAIL pc_wrap: got %h expected 0000", pc_out); end
  endtask

  task automatic test_wait_states();
    ir_load = 1'b1;
    step();
    // Three wait cycles; ir_load held high (ignored) and the PC bumped once.
    for (int i = 0; i < 3; i++) begin
      pc_write = (i == 0);
      vec++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 16'h0000 || instr !== 32'h0000FFFF) begin errs++;
        $display("FAIL wait_hold[%0d]: got req=%b addr=%h ir=%h expected 1/0000/0000ffff", i, imem_if.imem_req, imem_if.imem_addr, instr); end
      step();
    end
    pc_write = 1'b0;
    ir_load = 1'b0;
    vec++; if (imem_if.imem_req !== 1'b1 || imem_if.imem_addr !== 16'h0000) begin errs++;
      $display("FAIL wait_hold_last: got req=%b addr=%h expected 1/0000", imem_if.imem_req, imem_if.imem_addr); end
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h2A000007;
    step();
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h55555555;
    vec++; if (instr !== 32'h2A000007 || pc_out !== 16'h0001) begin errs++;
      $display("FAIL wait_ir: got ir=%h pc=%h expected 2a000007/0001", instr, pc_out); end
    step();
    vec++; if (imem_if.imem_req !== 1'b0 || fetch_busy !== 1'b0 || instr !== 32'h2A000007) begin errs++;
      $display("FAIL wait_no_requeue: got req=%b busy=%b ir=%h expected 0/0/2a000007", imem_if.imem_req, fetch_busy, instr); end
    imem_if.imem_rdata = '0;
  endtask

  task automatic test_ack_at_timeout();
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    vec++; if (imem_if.imem_addr !== 16'h0001) begin errs++; $display("FAIL late_addr: got %h expected 0001", imem_if.imem_addr); end
    for (int i = 0; i < 14; i++) step();
    vec++; if (imem_if.imem_req !== 1'b1) begin errs++; $display("FAIL late_req_15th: got %b expected 1", imem_if.imem_req); end
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h3B00000F;
    step();
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = '0;
    vec++; if (instr !== 32'h3B00000F || fetch_err !== 1'b0 || imem_if.imem_req !== 1'b0) begin errs++;
      $display("FAIL late_ack_wins: got ir=%h err=%b req=%b expected 3b00000f/0/0", instr, fetch_err, imem_if.imem_req); end
  endtask

  task automatic test_timeout();
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      vec++; if (imem_if.imem_req !== 1'b1 || fetch_err !== 1'b0) begin errs++;
        $display("FAIL to_wait[%0d]: got req=%b err=%b expected 1/0", i, imem_if.imem_req, fetch_err); end
      step();
    end
    vec++; if (imem_if.imem_req !== 1'b0 || fetch_busy !== 1'b0) begin errs++;
      $display("FAIL to_drop: got req=%b busy=%b expected 0/0", imem_if.imem_req, fetch_busy); end
    vec++; if (instr !== 32'h0 || fetch_err !== 1'b1) begin errs++;
      $display("FAIL to_noop: got ir=%h err=%b expected 00000000/1", instr, fetch_err); end
    do_fetch(32'h4C001234);
    vec++; if (instr !== 32'h4C001234 || fetch_err !== 1'b1) begin errs++;
      $display("FAIL to_sticky: got ir=%h err=%b expected 4c001234/1", instr, fetch_err); end
  endtask

  task automatic test_reset_mid_fetch();
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    step();
    rst_f = 1'b0;
    #1;
    vec++; if (imem_if.imem_req !== 1'b0 || fetch_busy !== 1'b0 || pc_out !== 16'h0) begin errs++;
      $display("FAIL rst_async: got req=%b busy=%b pc=%h expected 0/0/0000", imem_if.imem_req, fetch_busy, pc_out); end
    vec++; if (instr !== 32'h0 || fetch_err !== 1'b0) begin errs++;
      $display("FAIL rst_async_ir: got ir=%h err=%b expected 00000000/0", instr, fetch_err); end
    step();
    rst_f = 1'b1;
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hDEADBEEF;
    step();
    imem_if.imem_ack = 1'b0; imem_if.imem_rdata = '0;
    vec++; if (instr !== 32'h0 || imem_if.imem_req !== 1'b0) begin errs++;
      $display("FAIL rst_stale_ack: got ir=%h req=%b expected 00000000/0", instr, imem_if.imem_req); end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_basic_fetch();
    test_fetch_with_pc_write();
    test_branch();
    test_wait_states();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
